// File: rtl/trace_pkg.sv
// Shared types for the write-back commit trace buffer.
// Holds the record layout, serialiser states and counter widths.
package trace_pkg;

   localparam int SEQ_W  = 16;
   localparam int DROP_W = 16;

   typedef struct packed {
      logic [31:0]      pc;
      logic [4:0]       wb_reg;
      logic [31:0]      value;
      logic [SEQ_W-1:0] seq;
      logic             ovf;
   } trace_rec_t;

   typedef enum logic [1:0] {
      IDLE,
      B0,
      B1,
      B2
   } ser_state_e;

   // Middle beat: overflow flag, sequence number and destination register.
   function automatic logic [31:0] beat1(input trace_rec_t r);
      return {r.ovf, 10'b0, r.seq, r.wb_reg};
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous record FIFO with registered read port and level output.
// Pop must only be asserted when the FIFO holds at least one record.
module trace_fifo
   import trace_pkg::*;
#(
   parameter int  DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       push_i,
   input  trace_rec_t wdata_i,
   input  logic       pop_i,
   output trace_rec_t rdata_o,
   output logic [AW:0] count_o
);

   trace_rec_t        mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   trace_rec_t        rdata_q, rdata_d;

   // Pointer, level and read-register next state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      rdata_d  = rdata_q;
      if (push_i) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         rdata_d  = mem_q[rd_ptr_q];
      end
      unique case ({push_i, pop_i})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   // Control registers, cleared by reset to discard buffered records.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rdata_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         rdata_q  <= rdata_d;
      end
   end

   assign rdata_o = rdata_q;
   assign count_o = count_q;

endmodule

// File: rtl/wb_trace_buffer.sv
// Captures register-writing retirements and streams them as 3-beat records.
// Tracks dropped records and marks the first record after a gap.
module wb_trace_buffer
   import trace_pkg::*;
#(
   parameter int  DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              trace_en,
   input  logic [31:0]       debug_wb_pc,
   input  logic              debug_wb_ena,
   input  logic [4:0]        debug_wb_reg,
   input  logic [31:0]       debug_wb_value,
   output logic              tr_valid,
   input  logic              tr_ready,
   output logic [31:0]       tr_data,
   output logic              tr_last,
   output logic [DROP_W-1:0] drop_cnt,
   output logic [AW:0]       fifo_level
);

   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   ser_state_e        state_q, state_d;
   logic [SEQ_W-1:0]  seq_q, seq_d;
   logic              gap_q, gap_d;
   logic [DROP_W-1:0] drop_q, drop_d;

   logic       commit;
   logic       accept;
   logic       drop;
   logic       pop;
   logic       empty;
   logic       full;
   logic [AW:0] level;
   trace_rec_t wrec;
   trace_rec_t orec;

   assign commit = trace_en && debug_wb_ena && (debug_wb_reg != 5'd0);
   assign empty  = (level == '0);
   assign full   = (level == FULL);

   // A B2 handshake frees a slot in the same cycle it reloads the output.
   assign pop    = !empty &&
                   ((state_q == IDLE) ||
                    ((state_q == B2) && tr_ready));
   assign accept = commit && (!full || pop);
   assign drop   = commit && !accept;

   assign wrec.pc     = debug_wb_pc;
   assign wrec.wb_reg = debug_wb_reg;
   assign wrec.value  = debug_wb_value;
   assign wrec.seq    = seq_q;
   assign wrec.ovf    = gap_q;

   trace_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (accept),
      .wdata_i (wrec),
      .pop_i   (pop),
      .rdata_o (orec),
      .count_o (level)
   );

   // Sequence, gap flag and saturating drop counter next state.
   always_comb begin
      seq_d  = seq_q;
      gap_d  = gap_q;
      drop_d = drop_q;
      if (commit) begin
         seq_d = seq_q + 1'b1;
      end
      if (drop) begin
         gap_d = 1'b1;
         if (drop_q != '1) begin
            drop_d = drop_q + 1'b1;
         end
      end else if (accept) begin
         gap_d = 1'b0;
      end
   end

   // Serialiser next state: walk the beats, reload from the FIFO at B2.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (pop) state_d = B0;
         B0:   if (tr_ready) state_d = B1;
         B1:   if (tr_ready) state_d = B2;
         B2:   if (tr_ready) state_d = pop ? B0 : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Beat payload selection; valid depends only on registered state.
   always_comb begin
      tr_valid = 1'b0;
      tr_last  = 1'b0;
      tr_data  = '0;
      unique case (state_q)
         B0: begin
            tr_valid = 1'b1;
            tr_data  = orec.pc;
         end
         B1: begin
            tr_valid = 1'b1;
            tr_data  = beat1(orec);
         end
         B2: begin
            tr_valid = 1'b1;
            tr_last  = 1'b1;
            tr_data  = orec.value;
         end
         default: begin
            tr_valid = 1'b0;
         end
      endcase
   end

   // State registers; reset abandons any record in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         seq_q   <= '0;
         gap_q   <= 1'b0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         seq_q   <= seq_d;
         gap_q   <= gap_d;
         drop_q  <= drop_d;
      end
   end

   assign drop_cnt   = drop_q;
   assign fifo_level = level;

endmodule

// File: doc/wb_trace_buffer.md
# wb_trace_buffer

Commit-trace capture block sitting directly downstream of the CPU core's write-back debug ports (`debug_wb_pc`, `debug_wb_ena`, `debug_wb_reg`, `debug_wb_value`).

- Records every register-writing retirement into a FIFO.
- Serialises each record as a 3-beat, 32-bit valid/ready stream for the trace sink (UART bridge, BRAM logger or testbench checker).
- Counts records lost to back-pressure and flags the first record after each loss, so the sink knows the trace has a gap.

## Interface
Parameters:
- `DEPTH`, 16: FIFO depth in records; power of two, 2..256.
- `AW`, $clog2(DEPTH): FIFO pointer width; derived, not overridden.

Ports:
- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `trace_en`  in  1  capture enable; 0 ignores commits. Does not stop the output drain.
- `debug_wb_pc`  in  32  PC of the retiring instruction.
- `debug_wb_ena`  in  1  register write-enable of the retiring instruction.
- `debug_wb_reg`  in  5  destination register.
- `debug_wb_value`  in  32  write-back data.
- `tr_valid`  out  1  output beat valid.
- `tr_ready`  in  1  sink accepts beat.
- `tr_data`  out  32  beat payload.
- `tr_last`  out  1  high on beat 2 of a record.
- `drop_cnt`  out  16  dropped-record count; saturates at 16'hFFFF.
- `fifo_level`  out  AW+1  records held, excluding the record being serialised.

## Operation
- Commit event: `trace_en && debug_wb_ena && debug_wb_reg != 0`. Writes to x0 and bubbles are ignored.
- Every commit event increments the 16-bit `seq` counter, whether the record is accepted or dropped. `seq` wraps FFFF -> 0000. The record carries the pre-increment value.
- Push is accepted if `fifo_level < DEPTH`, or if a pop occurs in the same cycle. Otherwise the record is dropped, `drop_cnt` increments (saturating) and sticky `gap` is set.
- An accepted record stores `gap` as its `ovf` bit. `gap` clears on that accept. If a drop and an accept both occur, set wins.
- Serialiser FSM states:
  - `IDLE`: pops a record into the output register when the FIFO is non-empty -> `B0`.
  - `B0` -> `B1` -> `B2` on `tr_valid && tr_ready`.
  - `B2` handshake -> `B0` with the next record if the FIFO is non-empty (back-to-back), else `IDLE`.
- Beat contents:
  - B0 = pc.
  - B1 = {ovf, 10'b0, seq[15:0], reg[4:0]}.
  - B2 = value, with `tr_last`=1.
- The pop at the B2 handshake counts as the same-cycle pop for the full check.

## Timing
- Reset values: `tr_valid`=0, `tr_data`=0, `tr_last`=0, `drop_cnt`=0, `fifo_level`=0. Internally `seq`=0, `gap`=0, FSM=`IDLE`, pointers=0.
- A reset mid-record discards all buffered and in-flight data. No partial record is resumed.
- Latency into an empty buffer with an idle FSM: commit at edge N -> `tr_valid` with B0 after edge N+2 (one cycle FIFO write, one cycle pop/load). FIFO is not first-word-fall-through.
- Sustained throughput: 1 record per 3 cycles with `tr_ready` held high. The core can retire 1 per cycle, so drops under bursts are expected.
- While `tr_valid && !tr_ready`: `tr_data` and `tr_last` are held stable and `tr_valid` stays high.
- `tr_valid` never depends combinationally on `tr_ready`.
- `trace_en` falling mid-stream: buffered records still drain. `trace_en` takes effect on the same-cycle commit.

## Structure
- `trace_pkg` contains:
  - `trace_rec_t` struct {pc[31:0], reg[4:0], value[31:0], seq[15:0], ovf}.
  - Serialiser state enum `{IDLE, B0, B1, B2}`.
  - Constants `SEQ_W`=16 and `DROP_W`=16.
- One sub-module, `trace_fifo`: synchronous FIFO of `trace_rec_t`, `DEPTH` entries, registered read, with count output.
- Top level holds the commit filter, `seq`/`gap`/`drop_cnt` logic and the serialiser FSM.

## Test plan
- Reset, `tr_ready`=1; one commit pc=0x0000_0100, reg=5, value=0xDEAD_BEEF -> beats appear 2 cycles later as 0x0000_0100, 0x0000_0005 (seq 0), 0xDEAD_BEEF with `tr_last` on the third beat.
- Commits with reg=0, or with `debug_wb_ena`=0, or with `trace_en`=0 -> no output beats; `seq` is unchanged (next valid commit carries seq 0).
- `tr_ready`=0, then 20 consecutive commits with DEPTH=16 -> `fifo_level`=16 and `drop_cnt`=3 (one record is in the serialiser); after releasing `tr_ready`, exactly 17 records drain with seq 0..16. A 21st commit then carries ovf=1 and seq=20.
- Random `tr_ready` toggling during a 3-record burst -> `tr_data` is stable while stalled, no beats are duplicated or skipped, and records arrive in commit order.
- Full FIFO with a commit landing on the same cycle as a B2 handshake -> record accepted and `drop_cnt` unchanged.
- Assert `rst` while in B1 -> all outputs return to reset values immediately; after release a new commit produces seq 0.
